// File: rtl/and3_tree_pipe_if.sv
// and3_tree_pipe_if: valid/ready bus carrying reduction operands in and per-channel results out.
interface and3_tree_pipe_if #(
  parameter int NIN = 9,
  parameter int CH  = 4
);
  logic              IN_VALID;
  logic              IN_READY;
  logic [CH*NIN-1:0] A;
  logic [CH-1:0]     INV;
  logic              OUT_VALID;
  logic              OUT_READY;
  logic [CH-1:0]     Z;
  modport master (
    output IN_VALID, A, INV, OUT_READY,
    input  IN_READY, OUT_VALID, Z
  );
  modport slave (
    input  IN_VALID, A, INV, OUT_READY,
    output IN_READY, OUT_VALID, Z
  );
endinterface

// File: rtl/and3_tree_pipe.sv
// and3_tree_pipe: per-channel AND reduction through registered 3-input AND levels with valid/ready flow control.
module and3_tree_pipe #(
  parameter int NIN = 9,
  parameter int CH  = 4
) (
`ifdef USE_POWER_PINS
  inout wire VDD,
  inout wire VSS,
`endif
  input logic CLK,
  input logic RN,
  and3_tree_pipe_if.slave bus
);
  function automatic int lvl_w(input int k);
    int w;
    w = NIN;
    for (int i = 0; i < k; i++) w = (w + 2) / 3;
    return w;
  endfunction
  function automatic int num_lvl();
    int n;
    int w;
    n = 0;
    w = NIN;
    while (w > 1) begin
      w = (w + 2) / 3;
      n++;
    end
    return n;
  endfunction
  localparam int L = num_lvl();
  for (genvar s = 1; s <= L; s++) begin : st
    localparam int WI = lvl_w(s - 1);
    localparam int WO = lvl_w(s);
    logic [CH*WI-1:0] p;
    logic [CH-1:0]    p_inv;
    logic             p_v;
    logic [CH*WO-1:0] d_d;
    logic [CH*WO-1:0] d_q;
    logic [CH-1:0]    inv_q;
    logic             v_q;
    logic             up_rdy;
    logic             dn_rdy;
    if (s == 1) begin : g_src
      assign p     = bus.A;
      assign p_inv = bus.INV;
      assign p_v   = bus.IN_VALID;
    end else begin : g_src
      assign p     = st[s-1].d_q;
      assign p_inv = st[s-1].inv_q;
      assign p_v   = st[s-1].v_q;
    end
    if (s == L) begin : g_snk
      assign dn_rdy = bus.OUT_READY;
    end else begin : g_snk
      assign dn_rdy = st[s+1].up_rdy;
    end
    assign up_rdy = !v_q || dn_rdy;
    for (genvar c = 0; c < CH; c++) begin : ch
      // Short last group is filled with ones so it cannot clear the result.
      logic [3*WO-1:0] pad;
      always_comb begin
        pad         = '1;
        pad[WI-1:0] = p[c*WI +: WI];
      end
      for (genvar j = 0; j < WO; j++) begin : grp
        assign d_d[c*WO+j] = &pad[3*j +: 3];
      end
    end
    always_ff @(posedge CLK or negedge RN) begin
      if (!RN) begin
        v_q   <= 1'b0;
        d_q   <= '0;
        inv_q <= '0;
      end else if (up_rdy) begin
        v_q <= p_v;
        if (p_v) begin
          d_q   <= d_d;
          inv_q <= p_inv;
        end
      end
    end
  end
  assign bus.IN_READY  = st[1].up_rdy;
  assign bus.OUT_VALID = st[L].v_q;
  assign bus.Z         = st[L].d_q ^ st[L].inv_q;
endmodule

// File: tb/tb_and3_tree_pipe.sv
// tb_and3_tree_pipe: scoreboard bench for the pipelined AND tree (NIN=9/CH=4 and NIN=10/CH=1).
module tb_and3_tree_pipe;
  logic clk = 1'b0;
  logic rn;
  always #5 clk = ~clk;
  and3_tree_pipe_if #(.NIN(9),  .CH(4)) b9 ();
  and3_tree_pipe_if #(.NIN(10), .CH(1)) b10 ();
  and3_tree_pipe #(.NIN(9),  .CH(4)) dut9  (.CLK(clk), .RN(rn), .bus(b9));
  and3_tree_pipe #(.NIN(10), .CH(1)) dut10 (.CLK(clk), .RN(rn), .bus(b10));
  localparam logic [35:0] ONES = '1;
  int n_vec = 0;
  int n_err = 0;
  logic [3:0] sb[$];
  function automatic logic [3:0] ref9(input logic [35:0] a, input logic [3:0] inv);
    logic [3:0] z;
    for (int c = 0; c < 4; c++) z[c] = (a[c*9 +: 9] == 9'h1FF) ^ inv[c];
    return z;
  endfunction
  task automatic drive(input logic v, input logic [35:0] a, input logic [3:0] inv, input logic ordy);
    @(negedge clk);
    b9.IN_VALID  = v;
    b9.A         = a;
    b9.INV       = inv;
    b9.OUT_READY = ordy;
    #1;
  endtask
  task automatic test_reset;
    rn            = 1'b0;
    b9.IN_VALID   = 1'b0;
    b9.A          = '0;
    b9.INV        = '0;
    b9.OUT_READY  = 1'b1;
    b10.IN_VALID  = 1'b0;
    b10.A         = '0;
    b10.INV       = '0;
    b10.OUT_READY = 1'b1;
    #2;
    n_vec++;
    if (b9.OUT_VALID !== 1'b0) begin n_err++; $display("FAIL reset_valid9: got %b want 0", b9.OUT_VALID); end
    n_vec++;
    if (b9.Z !== 4'b0000) begin n_err++; $display("FAIL reset_z9: got %b want 0000", b9.Z); end
    n_vec++;
    if (b10.OUT_VALID !== 1'b0) begin n_err++; $display("FAIL reset_valid10: got %b want 0", b10.OUT_VALID); end
    @(negedge clk);
    rn = 1'b1;
  endtask
  task automatic test_basic;
    for (int i = 0; i < 5; i++) begin
      drive(i == 0, ONES, 4'b0000, 1'b1);
      n_vec++;
      if (b9.OUT_VALID !== (i == 2)) begin n_err++; $display("FAIL basic_valid cycle %0d: got %b want %b", i, b9.OUT_VALID, i == 2); end
      if (i == 2) begin
        n_vec++;
        if (b9.Z !== 4'b1111) begin n_err++; $display("FAIL basic_z: got %b want 1111", b9.Z); end
      end
    end
  endtask
  task automatic test_invert;
    logic [35:0] a;
    a = ONES;
    a[2*9+5] = 1'b0;
    for (int i = 0; i < 4; i++) begin
      drive(i == 0, a, 4'b0001, 1'b1);
      n_vec++;
      if (b9.OUT_VALID !== (i == 2)) begin n_err++; $display("FAIL invert_valid cycle %0d: got %b want %b", i, b9.OUT_VALID, i == 2); end
      if (i == 2) begin
        n_vec++;
        if (b9.Z !== 4'b1010) begin n_err++; $display("FAIL invert_z: got %b want 1010", b9.Z); end
      end
    end
  endtask
  task automatic test_backpressure;
    logic [35:0] wa [4];
    logic [3:0]  wi [4];
    logic [3:0]  e;
    int k;
    int idx;
    wa = '{ONES, ONES, ONES & ~36'h200, 36'h0};
    wi = '{4'h0, 4'hF, 4'h0, 4'h5};
    k = 0;
    sb.delete();
    for (int i = 0; i < 6; i++) begin
      idx = (k < 4) ? k : 3;
      drive(k < 4, wa[idx], wi[idx], 1'b0);
      n_vec++;
      if (b9.IN_READY !== (i < 2)) begin n_err++; $display("FAIL bp_in_ready cycle %0d: got %b want %b", i, b9.IN_READY, i < 2); end
      if (i >= 2) begin
        n_vec++;
        if (b9.OUT_VALID !== 1'b1 || b9.Z !== 4'b1111)
          begin n_err++; $display("FAIL bp_hold cycle %0d: got v=%b z=%b want v=1 z=1111", i, b9.OUT_VALID, b9.Z); end
      end
      if (b9.IN_VALID && b9.IN_READY) begin sb.push_back(ref9(wa[idx], wi[idx])); k++; end
    end
    for (int i = 0; i < 6; i++) begin
      idx = (k < 4) ? k : 3;
      drive(k < 4, wa[idx], wi[idx], 1'b1);
      n_vec++;
      if (b9.OUT_VALID !== (i < 4)) begin n_err++; $display("FAIL bp_drain_valid cycle %0d: got %b want %b", i, b9.OUT_VALID, i < 4); end
      if (b9.OUT_VALID) begin
        n_vec++;
        if (sb.size() == 0) begin n_err++; $display("FAIL bp_drain_extra: got z=%b want no output", b9.Z); end
        else begin
          e = sb.pop_front();
          if (b9.Z !== e) begin n_err++; $display("FAIL bp_drain_z cycle %0d: got %b want %b", i, b9.Z, e); end
        end
      end
      if (b9.IN_VALID && b9.IN_READY) begin sb.push_back(ref9(wa[idx], wi[idx])); k++; end
    end
    n_vec++;
    if (sb.size() != 0) begin n_err++; $display("FAIL bp_lost: got %0d pending want 0", sb.size()); end
  endtask
  task automatic test_padding;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      b10.IN_VALID  = (i < 2);
      b10.A         = (i == 0) ? 10'h3FF : 10'h1FF;
      b10.INV       = 1'b0;
      b10.OUT_READY = 1'b1;
      #1;
      n_vec++;
      if (b10.OUT_VALID !== (i == 3 || i == 4))
        begin n_err++; $display("FAIL pad_valid cycle %0d: got %b want %b", i, b10.OUT_VALID, i == 3 || i == 4); end
      if (i == 3) begin
        n_vec++;
        if (b10.Z !== 1'b1) begin n_err++; $display("FAIL pad_3ff: got %b want 1", b10.Z); end
      end
      if (i == 4) begin
        n_vec++;
        if (b10.Z !== 1'b0) begin n_err++; $display("FAIL pad_1ff: got %b want 0", b10.Z); end
      end
    end
  endtask
  task automatic test_reset_midflight;
    drive(1'b1, ONES, 4'h0, 1'b1);
    drive(1'b1, ONES, 4'h0, 1'b1);
    drive(1'b0, '0, 4'h0, 1'b1);
    n_vec++;
    if (b9.OUT_VALID !== 1'b1) begin n_err++; $display("FAIL mid_inflight: got %b want 1", b9.OUT_VALID); end
    #1 rn = 1'b0;
    #1;
    n_vec++;
    if (b9.OUT_VALID !== 1'b0) begin n_err++; $display("FAIL mid_async_valid: got %b want 0", b9.OUT_VALID); end
    n_vec++;
    if (b9.Z !== 4'b0000) begin n_err++; $display("FAIL mid_async_z: got %b want 0000", b9.Z); end
    @(negedge clk);
    rn = 1'b1;
    for (int i = 0; i < 7; i++) begin
      drive(i == 2, ONES, 4'h6, 1'b1);
      n_vec++;
      if (b9.OUT_VALID !== (i == 4)) begin n_err++; $display("FAIL mid_after_valid cycle %0d: got %b want %b", i, b9.OUT_VALID, i == 4); end
      if (i == 4) begin
        n_vec++;
        if (b9.Z !== 4'b1001) begin n_err++; $display("FAIL mid_after_z: got %b want 1001", b9.Z); end
      end
    end
  endtask
  task automatic test_streaming;
    logic [35:0] a;
    logic [3:0]  inv;
    logic [3:0]  e;
    logic [3:0]  prev_z;
    logic        prev_stall;
    logic        v;
    int acc;
    int cyc;
    int r;
    sb.delete();
    acc = 0;
    cyc = 0;
    prev_stall = 1'b0;
    prev_z = '0;
    while ((acc < 200 || sb.size() > 0) && cyc < 5000) begin
      for (int c = 0; c < 4; c++) begin
        r = $urandom_range(0, 2);
        a[c*9 +: 9] = (r == 0) ? 9'h1FF : (r == 1) ? (9'h1FF & ~(9'h1 << $urandom_range(0, 8))) : 9'($urandom);
      end
      inv = 4'($urandom);
      v = (acc < 200) && ($urandom_range(0, 3) != 0);
      drive(v, a, inv, $urandom_range(0, 2) != 0);
      if (prev_stall) begin
        n_vec++;
        if (b9.OUT_VALID !== 1'b1 || b9.Z !== prev_z)
          begin n_err++; $display("FAIL stream_stall cycle %0d: got v=%b z=%b want v=1 z=%b", cyc, b9.OUT_VALID, b9.Z, prev_z); end
      end
      if (b9.OUT_VALID && b9.OUT_READY) begin
        n_vec++;
        if (sb.size() == 0) begin n_err++; $display("FAIL stream_extra cycle %0d: got z=%b want no output", cyc, b9.Z); end
        else begin
          e = sb.pop_front();
          if (b9.Z !== e) begin n_err++; $display("FAIL stream_z cycle %0d: got %b want %b", cyc, b9.Z, e); end
        end
      end
      if (b9.IN_VALID && b9.IN_READY) begin sb.push_back(ref9(a, inv)); acc++; end
      prev_stall = b9.OUT_VALID && !b9.OUT_READY;
      prev_z = b9.Z;
      cyc++;
    end
    n_vec++;
    if (cyc >= 5000) begin n_err++; $display("FAIL stream_timeout: got %0d accepted %0d pending want 200 accepted 0 pending", acc, sb.size()); end
  endtask
  initial begin
    test_reset();
    test_basic();
    test_invert();
    test_backpressure();
    test_padding();
    test_reset_midflight();
    test_streaming();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
  initial begin
    #1000000;
    $display("FAIL watchdog: got no completion want finish before 1ms");
    $fatal(1, "watchdog expired");
  end
endmodule

// File: doc/and3_tree_pipe.md
Name: and3_tree_pipe

Overview:
- Parametrised, pipelined successor to the single 3-input AND cell.
- Each of CH independent channels AND-reduces NIN input bits through a tree of 3-input AND levels, with a register after every level.
- Data moves under a valid/ready handshake with full back-pressure, and each channel can optionally invert its result (NAND mode).
- Used as a wide-reduction macro (e.g. all-flags-set detection) between registered datapath stages.

Parameters:
- NIN, 9, input bits reduced per channel; legal range 2..243.
- CH, 4, number of independent channels; legal range 1..32.
- L, derived (not overridable), number of tree levels = ceil(log3(NIN)). Examples: NIN=2..3 gives L=1; 4..9 gives L=2; 10..27 gives L=3.

Ports:
- CLK  input  1  rising-edge clock.
- RN  input  1  asynchronous active-low reset.
- IN_VALID  input  1  A and INV are valid this cycle.
- IN_READY  output  1  pipeline accepts A/INV this cycle.
- A  input  CH*NIN  channel c occupies bits [c*NIN +: NIN].
- INV  input  CH  per-channel invert, travels with its data word.
- OUT_VALID  output  1  Z holds a result.
- OUT_READY  input  1  downstream accepts Z this cycle.
- Z  output  CH  per-channel result: AND of its NIN bits, XOR with INV[c].
- VDD, VSS  inout  1  present only under USE_POWER_PINS.

Behaviour:
- Clocking and reset: one clock domain (CLK) with asynchronous active-low reset RN.
- While RN=0:
  - all stage valid bits = 0, so OUT_VALID=0 immediately (asynchronous);
  - all data registers = 0, so Z=0;
  - all INV pipe registers = 0.
- Reset release: takes effect on the next CLK edge after RN rises.
- Reset mid-operation: all in-flight words are discarded, with no partial output.
- Tree structure:
  - Level k (1..L) groups the previous level's bits per channel in threes, LSB first: bits 3j, 3j+1, 3j+2 feed output bit j.
  - A missing operand in the last group is tied to 1 (padding), so padding never changes the result.
  - Level k output width per channel = ceil(previous width / 3); level L width = 1.
- Pipeline: each level has a register stage s=1..L holding the data, the INV vector and a valid bit v[s].
- Ready chain:
  - rdy[L] = OUT_READY.
  - rdy[s-1] = !v[s] || rdy[s].
  - IN_READY = rdy[0] (combinational from OUT_READY through the chain; no registered ready).
- Stage s loads when rdy[s-1]=1:
  - v[s] <= v[s-1] (v[0] = IN_VALID);
  - data and INV are captured only when the incoming valid = 1; otherwise the registers hold.
- Outputs:
  - Z = stage-L data XOR stage-L INV.
  - OUT_VALID = v[L].
- Latency and throughput:
  - latency is exactly L cycles from an accepted input (IN_VALID && IN_READY) to OUT_VALID, when OUT_READY is held 1;
  - throughput is 1 word/cycle.
- Back-pressure:
  - while OUT_VALID && !OUT_READY, Z and OUT_VALID hold stable;
  - bubbles in front of the stall continue to be squeezed out;
  - once all L stages are valid and stalled, IN_READY=0.
- Ordering and loss:
  - words are never dropped or duplicated;
  - output order equals acceptance order.
- Simultaneous accept and emit when full: stage L emits and all stages shift in the same cycle, so IN_READY=1 when OUT_READY=1.
- IN_VALID=0: creates a bubble; the A/INV value is a don't-care and does not affect Z.
- X on A while IN_VALID=0: must not propagate to Z.

Test Plan:
- Basic AND (NIN=9, CH=4): apply A all ones, INV=0, IN_VALID=1 for one cycle, OUT_READY=1 -> OUT_VALID=1 exactly 2 cycles later with Z=4'b1111, then OUT_VALID=0.
- Single zero and invert: clear channel 2 bit 5 and set INV=4'b0001 -> Z=4'b1010 after 2 cycles.
- Back-pressure (NIN=9):
  - stimulus: hold OUT_READY=0, offer words W0..W3 back-to-back;
  - required: W0 and W1 are accepted, then IN_READY=0;
  - required: Z stays at W0's result for the whole stall;
  - required: on OUT_READY=1, results appear in the order W0, W1, W2, W3 with no gap.
- Padding (NIN=10, L=3):
  - A=10'h3FF -> Z=1;
  - A=10'h1FF (only the padded-group bit 9 cleared) -> Z=0;
  - both after 3 cycles.
- Reset mid-flight:
  - stimulus: assert RN=0 asynchronously, between edges, while 2 words are in flight;
  - required: OUT_VALID=0 and Z=0 immediately;
  - required: after release, no stale word ever appears and a new word emerges after L cycles.
- Streaming:
  - stimulus: 200 random words, random IN_VALID and random OUT_READY;
  - required: the scoreboard matches reference AND/XOR per channel, in order, with no loss;
  - required: Z is stable whenever OUT_VALID && !OUT_READY.
